mod_square_gen: RTL and testbench

//  Square-wave bias modulation source for the PIG loop: drives the modulation DAC word,
//  the o_status half-period flag, o_polarity and the o_trig sample strobe consumed by
//  the error-signal demodulator. It is the transmit side of the status/polarity/trig

---
 rtl/mod_square_gen.sv | 171 +++++++++++++++++
 tb/tb_mod_square_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_square_gen.sv
// mod_square_gen: square-wave bias modulation source for the PIG loop.
// Drives the modulation DAC word plus the status/polarity/trig interface
// consumed by the error-signal demodulator.
// Optional build macro: MOD_SAT_EN clamps amplitudes to the DAC range
// instead of truncating them to DAC_BIT bits.
module mod_square_gen #(
  parameter int unsigned DAC_BIT  = 14,
  parameter int unsigned MIN_HALF = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_polarity,
  input  logic        [31:0]        i_freq_cnt,
  input  logic        [31:0]        i_trig_dly,
  input  logic signed [31:0]        i_amp_h,
  input  logic signed [31:0]        i_amp_l,
  output logic signed [DAC_BIT-1:0] o_mod_out,
  output logic                      o_status,
  output logic                      o_polarity,
  output logic                      o_trig,
  output logic                      o_period_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e                    state_q, state_d;
  logic                      r_en_q, r_pol_q;
  logic               [31:0] r_freq_q, r_dly_q;
  logic signed        [31:0] r_amph_q, r_ampl_q;
  logic               [31:0] half_q, half_d, trigpt_q, trigpt_d, cnt_q, cnt_d;
  logic signed        [31:0] amph_q, amph_d, ampl_q, ampl_d;
  logic                      status_q, status_d, pol_q;
  logic signed [DAC_BIT-1:0] mod_q, mod_d;
  logic               [31:0] half_calc, dly_calc;
  logic                      pol_change, trig, done;

  // Map a 32-bit amplitude onto the DAC word.
  function automatic logic signed [DAC_BIT-1:0] dac_word(input logic signed [31:0] amp);
`ifdef MOD_SAT_EN
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (DAC_BIT - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (DAC_BIT - 1));
    if (amp > hi)      return hi[DAC_BIT-1:0];
    else if (amp < lo) return lo[DAC_BIT-1:0];
    else               return amp[DAC_BIT-1:0];
`else
    return amp[DAC_BIT-1:0];
`endif
  endfunction

  // Register every control/data input once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en_q   <= 1'b0;
      r_pol_q  <= 1'b1;
      r_freq_q <= '0;
      r_dly_q  <= '0;
      r_amph_q <= '0;
      r_ampl_q <= '0;
    end else begin
      r_en_q   <= i_en;
      r_pol_q  <= i_polarity;
      r_freq_q <= i_freq_cnt;
      r_dly_q  <= i_trig_dly;
      r_amph_q <= i_amp_h;
      r_ampl_q <= i_amp_l;
    end
  end

  // Candidate shadow values: half length floored at MIN_HALF, delay kept inside the half.
  always_comb begin
    half_calc = ((r_freq_q >> 1) < MIN_HALF) ? MIN_HALF : (r_freq_q >> 1);
    dly_calc  = (r_dly_q > half_calc - 32'd1) ? half_calc - 32'd1 : r_dly_q;
  end

  // FSM next state, counter, shadows and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    status_d   = status_q;
    mod_d      = mod_q;
    half_d     = half_q;
    trigpt_d   = trigpt_q;
    amph_d     = amph_q;
    ampl_d     = ampl_q;
    trig       = 1'b0;
    done       = 1'b0;
    pol_change = (r_pol_q != pol_q);
    case (state_q)
      IDLE: begin
        status_d = 1'b0;
        mod_d    = '0;
        if (r_en_q) state_d = LOAD;
      end
      LOAD: begin
        half_d   = half_calc;
        trigpt_d = half_calc - 32'd1 - dly_calc;
        amph_d   = r_amph_q;
        ampl_d   = r_ampl_q;
        cnt_d    = half_calc - 32'd1;
        status_d = r_pol_q;
        mod_d    = dac_word(r_pol_q ? r_amph_q : r_ampl_q);
        state_d  = RUN;
      end
      RUN: begin
        if (!r_en_q) begin
          state_d  = IDLE;
          status_d = 1'b0;
          mod_d    = '0;
        end else if (pol_change) begin
          state_d = LOAD;
        end else begin
          trig = (cnt_q == trigpt_q);
          if (cnt_q == '0) begin
            status_d = ~status_q;
            // Second half ending closes the period: reload shadows for the next one.
            if (status_q != r_pol_q) begin
              done     = 1'b1;
              half_d   = half_calc;
              trigpt_d = half_calc - 32'd1 - dly_calc;
              amph_d   = r_amph_q;
              ampl_d   = r_ampl_q;
              cnt_d    = half_calc - 32'd1;
              mod_d    = dac_word(status_d ? r_amph_q : r_ampl_q);
            end else begin
              cnt_d = half_q - 32'd1;
              mod_d = dac_word(status_d ? amph_q : ampl_q);
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, shadow and registered output update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      trigpt_q <= '0;
      amph_q   <= '0;
      ampl_q   <= '0;
      status_q <= 1'b0;
      pol_q    <= 1'b1;
      mod_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      trigpt_q <= trigpt_d;
      amph_q   <= amph_d;
      ampl_q   <= ampl_d;
      status_q <= status_d;
      pol_q    <= r_pol_q;
      mod_q    <= mod_d;
    end
  end

  assign o_mod_out     = mod_q;
  assign o_status      = status_q;
  assign o_polarity    = pol_q;
  assign o_trig        = trig;
  assign o_period_done = done;

endmodule

// File: tb/tb_mod_square_gen.sv
// tb_mod_square_gen: directed self-checking bench for mod_square_gen.
module tb_mod_square_gen;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic               pol;
  logic        [31:0] freq_cnt;
  logic        [31:0] trig_dly;
  logic signed [31:0] amp_h;
  logic signed [31:0] amp_l;
  logic signed [13:0] mod_out;
  logic               status;
  logic               polarity;
  logic               trig;
  logic               period_done;

  int errors = 0;
  int checks = 0;

  mod_square_gen #(.DAC_BIT(14), .MIN_HALF(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_polarity   (pol),
    .i_freq_cnt   (freq_cnt),
    .i_trig_dly   (trig_dly),
    .i_amp_h      (amp_h),
    .i_amp_l      (amp_l),
    .o_mod_out    (mod_out),
    .o_status     (status),
    .o_polarity   (polarity),
    .o_trig       (trig),
    .o_period_done(period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; pol = 1'b1;
    freq_cnt = 32'd100; trig_dly = 32'd10; amp_h = 32'sd1000; amp_l = -32'sd1000;
    tick(); tick();
    checks++;
    if ({mod_out, status, polarity, trig, period_done} !== {14'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got mod=%0d st=%b pol=%b trig=%b done=%b, want 0 0 1 0 0",
               mod_out, status, polarity, trig, period_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int n = 0;
    do begin tick(); n++; end while (status !== 1'b1 && n < 10);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d clocks to first high half, want 3", n);
    end
    for (int c = 0; c < 200; c++) begin
      int pos = c % 100;
      logic es = (pos < 50);
      int em = es ? 1000 : -1000;
      logic et = ((pos % 50) == 10);
      logic ed = (pos == 99);
      if (c > 0) tick();
      checks++;
      if (status !== es || int'(mod_out) !== em || trig !== et || period_done !== ed || polarity !== 1'b1) begin
        errors++;
        $display("FAIL basic c=%0d: got st=%b mod=%0d trig=%b done=%b pol=%b, want st=%b mod=%0d trig=%b done=%b pol=1",
                 c, status, mod_out, trig, period_done, polarity, es, em, et, ed);
      end
    end
  endtask

  task automatic test_polarity;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (status !== 1'b1 || trig !== (c == 10)) begin
        errors++;
        $display("FAIL pol_pre c=%0d: got st=%b trig=%b, want st=1 trig=0", c, status, trig);
      end
    end
    pol = 1'b0;
    tick();
    checks++;
    if (polarity !== 1'b1 || trig !== 1'b0) begin
      errors++;
      $display("FAIL pol_detect: got pol=%b trig=%b, want pol=1 trig=0", polarity, trig);
    end
    tick();
    checks++;
    if (polarity !== 1'b0 || trig !== 1'b0 || period_done !== 1'b0) begin
      errors++;
      $display("FAIL pol_load: got pol=%b trig=%b done=%b, want pol=0 trig=0 done=0",
               polarity, trig, period_done);
    end
    for (int c = 0; c < 100; c++) begin
      logic es = (c >= 50);
      int em = es ? 1000 : -1000;
      logic et = ((c % 50) == 10);
      logic ed = (c == 99);
      tick();
      checks++;
      if (status !== es || int'(mod_out) !== em || trig !== et || period_done !== ed || polarity !== 1'b0) begin
        errors++;
        $display("FAIL pol_run c=%0d: got st=%b mod=%0d trig=%b done=%b pol=%b, want st=%b mod=%0d trig=%b done=%b pol=0",
                 c, status, mod_out, trig, period_done, polarity, es, em, et, ed);
      end
    end
  endtask

  task automatic test_freq_change;
    for (int c = 0; c < 160; c++) begin
      int h = (c < 100) ? 50 : 30;
      int pos = (c < 100) ? c : c - 100;
      logic es = (pos >= h);
      int em = es ? 1000 : -1000;
      logic et = ((pos % h) == 10);
      logic ed = (pos == 2 * h - 1);
      tick();
      checks++;
      if (status !== es || int'(mod_out) !== em || trig !== et || period_done !== ed) begin
        errors++;
        $display("FAIL freq c=%0d: got st=%b mod=%0d trig=%b done=%b, want st=%b mod=%0d trig=%b done=%b",
                 c, status, mod_out, trig, period_done, es, em, et, ed);
      end
      if (c == 29) freq_cnt = 32'd60;
    end
  endtask

  task automatic test_small_half;
    en = 1'b0; pol = 1'b1; freq_cnt = 32'd3; trig_dly = 32'd5;
    tick(); tick(); tick();
    checks++;
    if (mod_out !== 14'd0 || status !== 1'b0 || trig !== 1'b0 || period_done !== 1'b0) begin
      errors++;
      $display("FAIL idle: got mod=%0d st=%b trig=%b done=%b, want 0 0 0 0", mod_out, status, trig, period_done);
    end
    en = 1'b1;
    tick(); tick();
    for (int c = 0; c < 8; c++) begin
      int pos = c % 4;
      logic es = (pos < 2);
      int em = es ? 1000 : -1000;
      logic et = ((pos % 2) == 1);
      logic ed = (pos == 3);
      tick();
      checks++;
      if (status !== es || int'(mod_out) !== em || trig !== et || period_done !== ed) begin
        errors++;
        $display("FAIL small c=%0d: got st=%b mod=%0d trig=%b done=%b, want st=%b mod=%0d trig=%b done=%b",
                 c, status, mod_out, trig, period_done, es, em, et, ed);
      end
    end
  endtask

  task automatic test_sat;
    logic signed [31:0] ah;
    logic signed [31:0] al;
    logic signed [13:0] th;
    logic signed [13:0] tl;
    int eh;
    int el;
    ah = 32'sd20000;
    al = -32'sd20000;
`ifdef MOD_SAT_EN
    eh = 8191;
    el = -8192;
`else
    th = ah[13:0];
    tl = al[13:0];
    eh = th;
    el = tl;
`endif
    en = 1'b0;
    tick(); tick(); tick();
    amp_h = ah; amp_l = al; en = 1'b1;
    tick(); tick();
    for (int c = 0; c < 4; c++) begin
      int em = (c < 2) ? eh : el;
      tick();
      checks++;
      if (int'(mod_out) !== em) begin
        errors++;
        $display("FAIL sat c=%0d: got mod=%0d, want %0d", c, mod_out, em);
      end
    end
  endtask

  task automatic test_async_reset;
    en = 1'b0;
    tick(); tick(); tick();
    pol = 1'b1; freq_cnt = 32'd100; trig_dly = 32'd10; amp_h = 32'sd1000; amp_l = -32'sd1000;
    en = 1'b1;
    tick(); tick();
    for (int c = 0; c < 25; c++) tick();
    checks++;
    if (status !== 1'b1 || int'(mod_out) !== 1000) begin
      errors++;
      $display("FAIL areset_pre: got st=%b mod=%0d, want st=1 mod=1000", status, mod_out);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mod_out, status, polarity, trig, period_done} !== {14'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL areset_now: got mod=%0d st=%b pol=%b trig=%b done=%b, want 0 0 1 0 0",
               mod_out, status, polarity, trig, period_done);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    for (int c = 0; c < 60; c++) begin
      int pos = c % 100;
      logic es = (pos < 50);
      int em = es ? 1000 : -1000;
      logic et = ((pos % 50) == 10);
      tick();
      checks++;
      if (status !== es || int'(mod_out) !== em || trig !== et || period_done !== 1'b0) begin
        errors++;
        $display("FAIL areset_run c=%0d: got st=%b mod=%0d trig=%b done=%b, want st=%b mod=%0d trig=%b done=0",
                 c, status, mod_out, trig, period_done, es, em, et);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_polarity();
    test_freq_change();
    test_small_half();
    test_sat();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
